// File: rtl/conv_window_package.sv
// rtl/conv_window_package.sv - shared types and width helpers for the sliding-window generator
//
// Purpose: frame-tracking state enum and counter-width helpers used by
//          conv_window_gen and its line buffers.
// Ports:   none (package).

package conv_window_package;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Column counter width; never narrower than one bit so a 1-pixel line still elaborates.
   function automatic int lpCOL_W(input int img_w);
      return (img_w > 1) ? $clog2(img_w) : 1;
   endfunction

   // Row counter width, same rule as the column counter.
   function automatic int lpROW_W(input int img_h);
      return (img_h > 1) ? $clog2(img_h) : 1;
   endfunction

endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - single-line pixel delay memory with read-first access
//
// Purpose: holds one image line. The read is combinational at the same
//          address being written, so the old pixel of the column is seen
//          in the same cycle it is replaced.
// Ports:   iclk    - clock, write on rising edge
//          iwe     - write enable (one accepted pixel)
//          iaddr   - column address for both read and write
//          iwdata  - pixel to store
//          ordata  - pixel currently stored at iaddr

module conv_line_buf #(
   parameter int pDATA_W = 8,
   parameter int pDEPTH  = 32,
   parameter int pADDR_W = 5
) (
   input  logic               iclk,
   input  logic               iwe,
   input  logic [pADDR_W-1:0] iaddr,
   input  logic [pDATA_W-1:0] iwdata,
   output logic [pDATA_W-1:0] ordata
);

   logic [pDATA_W-1:0] mem [pDEPTH];

   // Contents are never reset: every location is rewritten before a window uses it.
   always_ff @(posedge iclk) begin
      if (iwe) begin
         mem[iaddr] <= iwdata;
      end
   end

   assign ordata = mem[iaddr];

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster-stream sliding-window generator feeding the convolution core
//
// Purpose: builds every full stride-1, unpadded pKERNEL_Y x pKERNEL_X window
//          from a raster pixel stream using pKERNEL_Y-1 line buffers and a
//          shift window, and strobes each complete window for one cycle.
// Ports:   iclk        - clock
//          irst_n      - asynchronous active-low reset
//          idata       - pixel value
//          ivalid      - idata valid this cycle
//          isof        - with ivalid, marks the pixel as (row 0, col 0)
//          owindow     - [row][col][bit]; row 0 is oldest, col 0 is leftmost
//          ocalc_en    - one-cycle strobe, owindow holds a complete window
//          oframe_done - one-cycle pulse after the last pixel of a frame

module conv_window_gen
   import conv_window_package::*;
#(
   parameter int pDATA_W   = 8,
   parameter int pKERNEL_X = 3,
   parameter int pKERNEL_Y = 3,
   parameter int pIMG_W    = 32,
   parameter int pIMG_H    = 32
) (
   input  logic                                          iclk,
   input  logic                                          irst_n,
   input  logic [pDATA_W-1:0]                            idata,
   input  logic                                          ivalid,
   input  logic                                          isof,
   output logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0] owindow,
   output logic                                          ocalc_en,
   output logic                                          oframe_done
);

   localparam int cCOL_W = lpCOL_W(pIMG_W);
   localparam int cROW_W = lpROW_W(pIMG_H);
   localparam int cLB_N  = (pKERNEL_Y > 1) ? pKERNEL_Y - 1 : 1;
   localparam logic [cCOL_W-1:0] cCOL_LAST = cCOL_W'(pIMG_W - 1);
   localparam logic [cROW_W-1:0] cROW_LAST = cROW_W'(pIMG_H - 1);

   typedef logic [pKERNEL_Y-1:0][pKERNEL_X-1:0][pDATA_W-1:0] win_t;

   state_t              state, state_nxt;
   logic [cCOL_W-1:0]   col, col_nxt, cur_col;
   logic [cROW_W-1:0]   row, row_nxt, cur_row;
   logic                accept, emit, last_px;
   logic [pDATA_W-1:0]  lb_rd [cLB_N];
   logic [pKERNEL_Y-1:0][pDATA_W-1:0] new_col;
   win_t                win, win_nxt;

   // A start-of-frame pixel is accepted in any state and is itself (0,0).
   assign accept  = ivalid && (isof || (state != IDLE));
   assign cur_col = isof ? '0 : col;
   assign cur_row = isof ? '0 : row;
   assign last_px = (cur_col == cCOL_LAST) && (cur_row == cROW_LAST);
   // The column test also rules out windows straddling a line wrap.
   assign emit    = accept && (int'(cur_row) >= pKERNEL_Y - 1)
                           && (int'(cur_col) >= pKERNEL_X - 1);

   // Line buffer k holds the line k+1 rows above the incoming pixel.
   if (pKERNEL_Y > 1) begin : g_lb
      for (genvar k = 0; k < pKERNEL_Y - 1; k++) begin : g_stage
         logic [pDATA_W-1:0] wdata;
         if (k == 0) begin : g_first
            assign wdata = idata;
         end else begin : g_chain
            assign wdata = lb_rd[k-1];
         end
         conv_line_buf #(
            .pDATA_W (pDATA_W),
            .pDEPTH  (pIMG_W),
            .pADDR_W (cCOL_W)
         ) u_lb (
            .iclk   (iclk),
            .iwe    (accept),
            .iaddr  (cur_col),
            .iwdata (wdata),
            .ordata (lb_rd[k])
         );
      end
   end else begin : g_no_lb
      assign lb_rd[0] = '0;
   end

   // Column entering the window: oldest line at row 0, live pixel at the bottom.
   always_comb begin
      new_col = '0;
      new_col[pKERNEL_Y-1] = idata;
      for (int y = 0; y < pKERNEL_Y - 1; y++) begin
         new_col[y] = lb_rd[pKERNEL_Y-2-y];
      end
   end

   always_comb begin
      win_nxt = win;
      for (int y = 0; y < pKERNEL_Y; y++) begin
         for (int x = 0; x < pKERNEL_X - 1; x++) begin
            win_nxt[y][x] = win[y][x+1];
         end
         win_nxt[y][pKERNEL_X-1] = new_col[y];
      end
   end

   // Next position and frame phase. The phase follows directly from the row the
   // next pixel will land on, which covers the 1-row kernel and restarts alike.
   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      if (accept) begin
         if (last_px) begin
            col_nxt = '0;
            row_nxt = '0;
         end else if (cur_col == cCOL_LAST) begin
            col_nxt = '0;
            row_nxt = cur_row + cROW_W'(1);
         end else begin
            col_nxt = cur_col + cCOL_W'(1);
            row_nxt = cur_row;
         end
         if (last_px) begin
            state_nxt = IDLE;
         end else if (int'(row_nxt) >= pKERNEL_Y - 1) begin
            state_nxt = STREAM;
         end else begin
            state_nxt = PRIME;
         end
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // The shift window moves on every accepted pixel; owindow only loads on a
   // complete window so it holds steady between strobes.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         win         <= '0;
         owindow     <= '0;
         ocalc_en    <= 1'b0;
         oframe_done <= 1'b0;
      end else begin
         if (accept) begin
            win <= win_nxt;
         end
         if (emit) begin
            owindow <= win_nxt;
         end
         ocalc_en    <= emit;
         oframe_done <= accept && last_px;
      end
   end

endmodule
